// File: rtl/register_file_if.sv
// register_file_if: bus bundle for the register bank (write control, load
// data, two read ports and the overflow flag). clk/rst are not included.
interface register_file_if #(
  parameter int NBits = 8,
  parameter int NRegs = 4
);
  localparam int SelW = (NRegs > 1) ? $clog2(NRegs) : 1;

  logic             e;
  logic [2:0]       funsel;
  logic [NRegs-1:0] regsel;
  logic [NBits-1:0] i;
  logic [SelW-1:0]  outasel;
  logic [SelW-1:0]  outbsel;
  logic [NBits-1:0] outa;
  logic [NBits-1:0] outb;
  logic             ovf;

  modport master (
    output e, funsel, regsel, i, outasel, outbsel,
    input  outa, outb, ovf
  );

  modport slave (
    input  e, funsel, regsel, i, outasel, outbsel,
    output outa, outb, ovf
  );
endinterface

// File: rtl/register_file.sv
// register_file: NRegs x NBits register bank. One function code is applied
// in the same cycle to every register selected by regsel. Two combinational
// read ports, and a registered flag for inc/dec boundary hits.
// Optional build macro REGFILE_SAT_EN: inc/dec saturate instead of wrapping;
// ovf then means "saturated".
module register_file #(
  parameter int NBits = 8,
  parameter int NRegs = 4
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);
  localparam int SelW = (NRegs > 1) ? $clog2(NRegs) : 1;
  localparam int H    = NBits / 2;
  localparam logic [NBits-1:0] ONE = NBits'(1);

  logic [NRegs-1:0][NBits-1:0] regs_q, regs_d;
  logic                        ovf_q, ovf_d;

  // Increment with wrap-around, or holding at all-ones in the saturating build
  function automatic logic [NBits-1:0] inc_op(input logic [NBits-1:0] v);
`ifdef REGFILE_SAT_EN
    return (&v) ? v : v + ONE;
`else
    return v + ONE;
`endif
  endfunction

  // Decrement with wrap-around, or holding at zero in the saturating build
  function automatic logic [NBits-1:0] dec_op(input logic [NBits-1:0] v);
`ifdef REGFILE_SAT_EN
    return (v == '0) ? v : v - ONE;
`else
    return v - ONE;
`endif
  endfunction

  // Next-state: apply funsel to each selected register; flag boundary hits
  always_comb begin
    regs_d = regs_q;
    ovf_d  = 1'b0;
    if (bus.e) begin
      for (int k = 0; k < NRegs; k++) begin
        if (bus.regsel[k]) begin
          case (bus.funsel)
            3'b000: regs_d[k] = '0;
            3'b001: regs_d[k] = bus.i;
            3'b010: begin
              if (regs_q[k] == '0) ovf_d = 1'b1;
              regs_d[k] = dec_op(regs_q[k]);
            end
            3'b011: begin
              if (&regs_q[k]) ovf_d = 1'b1;
              regs_d[k] = inc_op(regs_q[k]);
            end
            3'b100: regs_d[k] = {regs_q[k][NBits-2:0], 1'b0};
            3'b101: regs_d[k] = {1'b0, regs_q[k][NBits-1:1]};
            3'b110: regs_d[k][H-1:0] = bus.i[H-1:0];
            default: regs_d[k] = regs_q[k];
          endcase
        end
      end
    end
  end

  // State registers; async reset clears the bank and the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ovf_q  <= ovf_d;
    end
  end

  // Read ports: index decode so out-of-range indices read as zero
  always_comb begin
    bus.outa = '0;
    bus.outb = '0;
    for (int k = 0; k < NRegs; k++) begin
      if (bus.outasel == SelW'(k)) bus.outa = regs_q[k];
      if (bus.outbsel == SelW'(k)) bus.outb = regs_q[k];
    end
  end

  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives a 4-register and a 3-register instance with the
// same operation stream and compares them against a behavioural model.
module tb_register_file;
`ifdef REGFILE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic [2:0] fs;
  logic [7:0] din;
  logic [3:0] rs4;
  logic [2:0] rs3;
  logic [1:0] asel, bsel;

  int checks   = 0;
  int failures = 0;

  int m[2][4];
  bit mov[2];

  always #5 clk = ~clk;

  register_file_if #(.NBits(8), .NRegs(4)) bus4 ();
  register_file_if #(.NBits(8), .NRegs(3)) bus3 ();

  assign bus4.e = e;       assign bus3.e = e;
  assign bus4.funsel = fs; assign bus3.funsel = fs;
  assign bus4.i = din;     assign bus3.i = din;
  assign bus4.regsel = rs4;
  assign bus3.regsel = rs3;
  assign bus4.outasel = asel; assign bus3.outasel = asel;
  assign bus4.outbsel = bsel; assign bus3.outbsel = bsel;

  register_file #(.NBits(8), .NRegs(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  register_file #(.NBits(8), .NRegs(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rd(input int d, input int nr, input int s);
    return (s < nr) ? m[d][s] : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) m[d][k] = 0;
      mov[d] = 1'b0;
    end
  endtask

  // One rising edge of the model for instance d with nr registers
  task automatic model_edge(input int d, input int nr, input int rsel);
    bit ov;
    ov = 1'b0;
    if (e) begin
      for (int k = 0; k < nr; k++) begin
        if (rsel[k]) begin
          case (int'(fs))
            0: m[d][k] = 0;
            1: m[d][k] = int'(din);
            2: if (m[d][k] == 0) begin ov = 1'b1; m[d][k] = SAT ? 0 : 255; end
               else m[d][k] = m[d][k] - 1;
            3: if (m[d][k] == 255) begin ov = 1'b1; m[d][k] = SAT ? 255 : 0; end
               else m[d][k] = m[d][k] + 1;
            4: m[d][k] = (m[d][k] * 2) % 256;
            5: m[d][k] = m[d][k] / 2;
            6: m[d][k] = (m[d][k] / 16) * 16 + (int'(din) % 16);
            default: ;
          endcase
        end
      end
    end
    mov[d] = ov;
  endtask

  task automatic check_ports();
    check("outa4", bus4.outa, rd(0, 4, int'(asel)));
    check("outb4", bus4.outb, rd(0, 4, int'(bsel)));
    check("ovf4",  bus4.ovf,  mov[0]);
    check("outa3", bus3.outa, rd(1, 3, int'(asel)));
    check("outb3", bus3.outb, rd(1, 3, int'(bsel)));
    check("ovf3",  bus3.ovf,  mov[1]);
  endtask

  task automatic step();
    if (rst) model_reset();
    else begin
      model_edge(0, 4, int'(rs4));
      model_edge(1, 3, int'(rs3));
    end
    @(posedge clk);
    #1;
    check_ports();
  endtask

  task automatic op(input logic [2:0] f, input logic [3:0] r4, input logic [2:0] r3,
                    input logic [7:0] d);
    e = 1'b1; fs = f; rs4 = r4; rs3 = r3; din = d;
    step();
  endtask

  // Sweep every read index on both ports (index 3 is out of range for dut3)
  task automatic check_all();
    logic [1:0] sa, sb;
    sa = asel; sb = bsel;
    for (int s = 0; s < 4; s++) begin
      asel = 2'(s); bsel = 2'(3 - s);
      #1;
      check("sweep_a4", bus4.outa, rd(0, 4, s));
      check("sweep_b4", bus4.outb, rd(0, 4, 3 - s));
      check("sweep_a3", bus3.outa, rd(1, 3, s));
      check("sweep_b3", bus3.outb, rd(1, 3, 3 - s));
    end
    asel = sa; bsel = sb;
    #1;
  endtask

  initial begin
    rst = 1'b0; e = 1'b0; fs = 3'd7; din = '0; rs4 = '0; rs3 = '0; asel = 2'd0; bsel = 2'd1;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_outa", bus4.outa, 8'h00);
    check("reset_outb", bus4.outb, 8'h00);
    check("reset_ovf",  bus4.ovf,  1'b0);
    step();
    step();
    rst = 1'b0;

    // Load every register, then an async reset pulse between edges
    op(3'b001, 4'b1111, 3'b111, 8'hA5);
    check_all();
    #1 rst = 1'b1;
    #1;
    check("async_outa", bus4.outa, 8'h00);
    check("async_outb", bus4.outb, 8'h00);
    check("async_ovf",  bus4.ovf,  1'b0);
    model_reset();
    #1 rst = 1'b0;
    asel = 2'd1; bsel = 2'd0;
    op(3'b001, 4'b0010, 3'b010, 8'h11);
    check("post_rst_load", bus4.outa, 8'h11);

    // Masked load, then the same inputs with e=0
    op(3'b001, 4'b0101, 3'b101, 8'h3C);
    asel = 2'd0; bsel = 2'd1;
    #1;
    check("masked_r0", bus4.outa, 8'h3C);
    check("masked_r1", bus4.outb, 8'h11);
    check_all();
    e = 1'b0; din = 8'h77;
    step();
    check_all();

    // Increment wrap and ovf, hold clears ovf, decrement of zero
    asel = 2'd1;
    op(3'b001, 4'b0010, 3'b010, 8'hFE);
    op(3'b011, 4'b0010, 3'b010, 8'h00);
    check("inc_fe", bus4.outa, 8'hFF);
    check("inc_fe_ovf", bus4.ovf, 1'b0);
    op(3'b011, 4'b0010, 3'b010, 8'h00);
    check("inc_ff", bus4.outa, SAT ? 8'hFF : 8'h00);
    check("inc_ff_ovf", bus4.ovf, 1'b1);
    op(3'b111, 4'b0010, 3'b010, 8'h00);
    check("hold_ovf", bus4.ovf, 1'b0);
    asel = 2'd0;
    op(3'b000, 4'b0001, 3'b001, 8'h00);
    op(3'b010, 4'b0001, 3'b001, 8'h00);
    check("dec_0", bus4.outa, SAT ? 8'h00 : 8'hFF);
    check("dec_0_ovf", bus4.ovf, 1'b1);

    // Shifts and low-half load
    asel = 2'd2;
    op(3'b001, 4'b0100, 3'b100, 8'h81);
    op(3'b100, 4'b0100, 3'b100, 8'h00);
    check("shl", bus4.outa, 8'h02);
    op(3'b101, 4'b0100, 3'b100, 8'h00);
    check("shr", bus4.outa, 8'h01);
    op(3'b001, 4'b0100, 3'b100, 8'hF0);
    op(3'b110, 4'b0100, 3'b100, 8'h5A);
    check("half_load", bus4.outa, 8'hFA);

    // Both ports on R3; read-during-write shows the old value until the edge
    asel = 2'd3; bsel = 2'd3;
    op(3'b001, 4'b1000, 3'b000, 8'hC3);
    e = 1'b1; fs = 3'b001; rs4 = 4'b1000; rs3 = 3'b000; din = 8'h3C;
    #1;
    check("rdw_old_a", bus4.outa, 8'hC3);
    check("rdw_old_b", bus4.outb, 8'hC3);
    step();
    check("rdw_new_a", bus4.outa, 8'h3C);
    check("rdw_new_b", bus4.outb, 8'h3C);
    check("oob_read3", bus3.outa, 8'h00);

    // Three-register instance: multi-select increment with one at all-ones
    op(3'b001, 4'b0000, 3'b111, 8'h10);
    op(3'b001, 4'b0000, 3'b100, 8'hFF);
    op(3'b011, 4'b0000, 3'b111, 8'h00);
    check("multi_inc_ovf3", bus3.ovf, 1'b1);
    check("multi_inc_ovf4", bus4.ovf, 1'b0);
    check_all();

    // Reset held across an enabled edge overrides the write
    e = 1'b1; fs = 3'b001; rs4 = 4'b1111; rs3 = 3'b111; din = 8'hEE;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all();

    // Randomised operation stream
    for (int n = 0; n < 300; n++) begin
      e    = ($urandom_range(0, 7) != 0);
      fs   = 3'($urandom_range(0, 7));
      rs4  = 4'($urandom);
      rs3  = 3'($urandom);
      din  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      asel = 2'($urandom);
      bsel = 2'($urandom);
      step();
    end
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Parametrised bank of NRegs general-purpose registers of NBits each, the successor to the single funsel-controlled register. One function code is applied in the same cycle to every register whose regsel bit is set. Two independent combinational read ports expose any register. A registered overflow flag reports inc/dec wrap-around (or saturation). It sits between the ALU result bus and the ALU operand muxes of the datapath.

## Interface
- NBits, 8: register width; must be ≥ 2.
- NRegs, 4: number of registers; must be ≥ 2. SelW = $clog2(NRegs).
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous, active-high reset.
- e  input  1: global write enable; 0 means every register holds.
- funsel  input  3: function code, see Operation.
- regsel  input  NRegs: write mask; bit k set means register k executes funsel.
- i  input  NBits: load data.
- outasel  input  SelW: read port A index.
- outbsel  input  SelW: read port B index.
- outa  output  NBits: contents of register outasel.
- outb  output  NBits: contents of register outbsel.
- ovf  output  1: registered overflow/saturation flag.

## Operation
- Decided: one clock (clk); reset rst is asynchronous and active-high.
- funsel codes, applied at the rising edge to each selected register R when e=1:
  - 000: clear, R ← 0.
  - 001: load, R ← i.
  - 010: decrement, R ← R − 1.
  - 011: increment, R ← R + 1.
  - 100: shift left logical, R ← {R[NBits-2:0], 0}.
  - 101: shift right logical, R ← {0, R[NBits-1:1]}.
  - 110: load low half; R[H-1:0] ← i[H-1:0] with H = NBits/2 (floor); upper bits kept.
  - 111: hold.
- Unselected registers always hold. regsel = 0 is legal and writes nothing.
- Multiple selected registers each apply the op to their own current value, independently.
- Arithmetic is modulo 2^NBits. Inc of all-ones wraps to 0; dec of 0 wraps to all-ones.
- ovf is updated at every rising edge:
  - Set to 1 iff e=1, funsel is 010 or 011, and at least one selected register is at the boundary (all-ones for inc, 0 for dec).
  - Otherwise set to 0, including when e=0.
- Reads:
  - outa and outb are purely combinational from current register state.
  - An index ≥ NRegs (non-power-of-two NRegs) reads as 0.
  - Both ports may select the same register.

## Timing
- Reset: all registers 0 and ovf 0, immediately on rst assertion, independent of clk. outa and outb read 0.
- Reset asserted mid-operation overrides any write in that cycle. The first write takes effect at the first rising edge after rst deasserts.
- Write latency is 1 cycle: a new value appears on outa/outb after the rising edge that performs the write, never before.
- Read-during-write: the read ports show the old value until the edge.
- ovf is valid from the same edge as the register update it describes, and lasts exactly one cycle unless the condition repeats.
- Inputs must be stable around the rising edge. No handshake applies; every enabled edge performs the operation.

## Configuration
- REGFILE_SAT_EN defined:
  - Inc at all-ones holds all-ones; dec at 0 holds 0.
  - ovf asserts under the same boundary conditions, meaning "saturated".
- REGFILE_SAT_EN undefined: modulo wrap-around as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Reset/async: with NBits=8 and NRegs=4, load all registers to 0xA5, then pulse rst between clock edges → outa and outb read 0x00 immediately and ovf=0; a load after rst falls lands on the next edge.
- Masked load: regsel=0101, i=0x3C, funsel=001, e=1 → R0=R2=0x3C and R1=R3 unchanged; e=0 with the same inputs → nothing changes.
- Wrap and ovf: R1=0xFE, inc twice → 0xFF with ovf=0, then 0x00 with ovf=1; a following hold edge → ovf=0. Dec of 0 → 0xFF with ovf=1. With REGFILE_SAT_EN: 0xFF inc → 0xFF with ovf=1, and 0 dec → 0 with ovf=1.
- Shifts and half-load: R2=0x81; shl → 0x02; shr → 0x01; funsel=110 with i=0x5A on R2=0xF0 → 0xFA.
- Read ports: outasel=outbsel=3 → both show R3. During a write to R3, both show the old value until the edge and the new value after it.
- NRegs=3: outasel=3 → outa=0; regsel=111 with inc → all three registers increment, and ovf reflects any one of them at all-ones.
